// File: rtl/enemy_pkg.sv
// enemy_pkg: shared types and constants for the enemy-plane lifecycle controller.
//   slot_state_t - per-slot lifecycle (idle, flying, retiring)
//   game_state_t - game flow (waiting for first start, playing, game over)
//   popcount32   - population count used for per-cycle kill/escape scoring
// Optional build macro SPAWN_JITTER_EN (see enemy_spawn_ctrl) uses LFSR_SEED.
package enemy_pkg;

    localparam int unsigned NUM_SLOTS_DEF = 10;
    localparam int unsigned LIVES_W       = 3;
    localparam int unsigned KILLS_W       = 8;
    localparam logic [7:0]  LFSR_SEED     = 8'h5A;

    typedef enum logic [1:0] {
        SlotIdle,
        SlotFly,
        SlotRetire
    } slot_state_t;

    typedef enum logic [1:0] {
        GameWait,
        GamePlay,
        GameOver
    } game_state_t;

    function automatic int unsigned popcount32(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/enemy_slot_fsm.sv
// enemy_slot_fsm: lifecycle of one enemy-plane slot (idle -> fly -> retire -> idle).
// Ports:
//   clk, reset        - clock and synchronous active-high reset
//   grant             - spawn grant from the top-level selector (honoured in idle only)
//   hit, touch_edge   - collision pulse / bottom-edge flag (honoured in fly only)
//   force_retire      - game is ending; retire a flying plane without scoring
//   c_en              - registered, high while flying
//   des               - registered, one-cycle pulse while retiring (clears Y)
//   kill_pulse        - combinational, this cycle retires the plane on a hit
//   escape_pulse      - combinational, this cycle retires the plane on an escape
module enemy_slot_fsm
    import enemy_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic grant,
    input  logic hit,
    input  logic touch_edge,
    input  logic force_retire,
    output logic c_en,
    output logic des,
    output logic kill_pulse,
    output logic escape_pulse
);

    slot_state_t state_q, state_d;
    logic        c_en_q, des_q;

    always_comb begin
        state_d      = state_q;
        kill_pulse   = 1'b0;
        escape_pulse = 1'b0;
        case (state_q)
            SlotIdle: begin
                if (grant) state_d = SlotFly;
            end
            SlotFly: begin
                // A hit outranks an edge touch in the same cycle.
                if (hit) begin
                    state_d    = SlotRetire;
                    kill_pulse = 1'b1;
                end else if (touch_edge) begin
                    state_d      = SlotRetire;
                    escape_pulse = 1'b1;
                end else if (force_retire) begin
                    state_d = SlotRetire;
                end
            end
            SlotRetire: state_d = SlotIdle;
            default:    state_d = SlotIdle;
        endcase
    end

    // Outputs are decoded from the next state so they leave a flop directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SlotIdle;
            c_en_q  <= 1'b0;
            des_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c_en_q  <= (state_d == SlotFly);
            des_q   <= (state_d == SlotRetire);
        end
    end

    assign c_en = c_en_q;
    assign des  = des_q;

endmodule

// File: rtl/enemy_spawn_ctrl.sv
// enemy_spawn_ctrl: game flow, spawn scheduling and scoring for the enemy-plane slots.
// Parameters: NUM_SLOTS (<= 32), SPAWN_INTERVAL (>= 2), LIVES_INIT (<= 7).
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   start               - one-cycle pulse, starts/restarts a game from wait or over
//   touch_edge, hit     - per-slot edge flags and collision pulses
//   c_en, des           - per-slot counter enable and destroy pulse
//   move_en             - global move enable, high while playing
//   flying_rate         - min(kills >> 4, 3)
//   kills, lives        - saturating score and remaining lives
//   game_over           - high in the over state
// Build macro SPAWN_JITTER_EN: adds 0-15 cycles of LFSR jitter to every timer reload.
module enemy_spawn_ctrl
    import enemy_pkg::*;
#(
    parameter int unsigned NUM_SLOTS      = NUM_SLOTS_DEF,
    parameter int unsigned SPAWN_INTERVAL = 16,
    parameter int unsigned LIVES_INIT     = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_SLOTS-1:0] touch_edge,
    input  logic [NUM_SLOTS-1:0] hit,
    output logic [NUM_SLOTS-1:0] c_en,
    output logic [NUM_SLOTS-1:0] des,
    output logic                 move_en,
    output logic [1:0]           flying_rate,
    output logic [KILLS_W-1:0]   kills,
    output logic [LIVES_W-1:0]   lives,
    output logic                 game_over
);

    localparam int unsigned PTR_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    // One bit beyond the 24-bit interval so the jittered reload cannot overflow.
    localparam int unsigned TIMER_W   = 25;
    localparam int unsigned KILLS_MAX = (1 << KILLS_W) - 1;
    localparam logic [TIMER_W-1:0] RELOAD_BASE = TIMER_W'(SPAWN_INTERVAL - 1);

    game_state_t          state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d, ptr_next;
    logic [KILLS_W-1:0]   kills_q, kills_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic [1:0]           rate_q, rate_d;
    logic                 move_en_q, game_over_q;

    logic [NUM_SLOTS-1:0] grant, kill_pulse, escape_pulse, slot_idle;
    logic                 restart, force_retire, spawn_tick, found;
    logic [TIMER_W-1:0]   reload_val;
    int unsigned          idx, kill_cnt, esc_cnt, kill_sum;

    assign restart      = start && (state_q != GamePlay);
    // Lives hit zero last cycle: retire everything and stop spawning.
    assign force_retire = (state_q == GamePlay) && (lives_q == '0);
    assign spawn_tick   = (state_q == GamePlay) && (timer_q == '0) && !force_retire;
    assign slot_idle    = ~(c_en | des);

`ifdef SPAWN_JITTER_EN
    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        if (restart) lfsr_d = LFSR_SEED;
    end

    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= lfsr_d;
    end

    assign reload_val = RELOAD_BASE + TIMER_W'(lfsr_q[3:0]);
`else
    assign reload_val = RELOAD_BASE;
`endif

    // Circular first-idle search starting at the pointer.
    always_comb begin
        grant    = '0;
        ptr_next = ptr_q;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= NUM_SLOTS) idx = idx - NUM_SLOTS;
            if (spawn_tick && !found && slot_idle[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
                ptr_next   = (idx == NUM_SLOTS - 1) ? '0 : PTR_W'(idx + 1);
            end
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        enemy_slot_fsm u_slot (
            .clk          (clk),
            .reset        (reset),
            .grant        (grant[g]),
            .hit          (hit[g]),
            .touch_edge   (touch_edge[g]),
            .force_retire (force_retire),
            .c_en         (c_en[g]),
            .des          (des[g]),
            .kill_pulse   (kill_pulse[g]),
            .escape_pulse (escape_pulse[g])
        );
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        ptr_d    = ptr_next;
        kill_cnt = popcount32(32'(kill_pulse));
        esc_cnt  = popcount32(32'(escape_pulse));
        kill_sum = 32'(kills_q) + kill_cnt;

        kills_d = (kill_sum > KILLS_MAX) ? KILLS_W'(KILLS_MAX) : KILLS_W'(kill_sum);
        lives_d = (esc_cnt >= 32'(lives_q)) ? '0 : lives_q - LIVES_W'(esc_cnt);

        case (state_q)
            GameWait, GameOver: begin
                if (start) begin
                    state_d = GamePlay;
                    timer_d = reload_val;
                    ptr_d   = '0;
                    kills_d = '0;
                    lives_d = LIVES_W'(LIVES_INIT);
                end
            end
            GamePlay: begin
                timer_d = (timer_q == '0) ? reload_val : timer_q - TIMER_W'(1);
                if (lives_q == '0) state_d = GameOver;
            end
            default: state_d = GameWait;
        endcase

        rate_d = (kills_d >= KILLS_W'(48)) ? 2'd3 : kills_d[5:4];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= GameWait;
            timer_q     <= RELOAD_BASE;
            ptr_q       <= '0;
            kills_q     <= '0;
            lives_q     <= LIVES_W'(LIVES_INIT);
            rate_q      <= 2'd0;
            move_en_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            ptr_q       <= ptr_d;
            kills_q     <= kills_d;
            lives_q     <= lives_d;
            rate_q      <= rate_d;
            move_en_q   <= (state_d == GamePlay);
            game_over_q <= (state_d == GameOver);
        end
    end

    assign move_en     = move_en_q;
    assign flying_rate = rate_q;
    assign kills       = kills_q;
    assign lives       = lives_q;
    assign game_over   = game_over_q;

endmodule

// File: tb/tb_enemy_spawn_ctrl.sv
// Bench for enemy_spawn_ctrl: expectations are queued with a target cycle as stimulus
// is scheduled, and the monitor pops and compares them when that cycle's outputs appear.
module tb_enemy_spawn_ctrl;

    localparam int unsigned NS = 10;

    logic          clk;
    logic          reset;
    logic          start;
    logic [NS-1:0] touch_edge;
    logic [NS-1:0] hit;
    logic [NS-1:0] c_en;
    logic [NS-1:0] des;
    logic          move_en;
    logic [1:0]    flying_rate;
    logic [7:0]    kills;
    logic [2:0]    lives;
    logic          game_over;

    enemy_spawn_ctrl #(
        .NUM_SLOTS      (NS),
        .SPAWN_INTERVAL (16),
        .LIVES_INIT     (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .touch_edge  (touch_edge),
        .hit         (hit),
        .c_en        (c_en),
        .des         (des),
        .move_en     (move_en),
        .flying_rate (flying_rate),
        .kills       (kills),
        .lives       (lives),
        .game_over   (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum {FCen, FDes, FMove, FRate, FKills, FLives, FOver} fld_e;
    typedef struct {
        int          cyc;
        string       tag;
        fld_e        fld;
        int unsigned val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_bad    = 0;

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int unsigned actual(input fld_e f);
        case (f)
            FCen:    return 32'(c_en);
            FDes:    return 32'(des);
            FMove:   return 32'(move_en);
            FRate:   return 32'(flying_rate);
            FKills:  return 32'(kills);
            FLives:  return 32'(lives);
            default: return 32'(game_over);
        endcase
    endfunction

    task automatic expect_at(input int c, input string tag, input fld_e f,
                             input int unsigned v);
        exp_t e;
        e.cyc = c;
        e.tag = tag;
        e.fld = f;
        e.val = v;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                check_val(sb[i].tag, actual(sb[i].fld), sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic wait_until(input int c);
        if (cyc > c) check_val("schedule", 32'(cyc), 32'(c));
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse_at(input int c, input logic st, input logic [NS-1:0] h,
                            input logic [NS-1:0] t);
        wait_until(c);
        start      = st;
        hit        = h;
        touch_edge = t;
        @(negedge clk);
        start      = 1'b0;
        hit        = '0;
        touch_edge = '0;
    endtask

    task automatic expect_reset_vals(input int c, input string pfx);
        expect_at(c, {pfx, "_c_en"},  FCen,   0);
        expect_at(c, {pfx, "_des"},   FDes,   0);
        expect_at(c, {pfx, "_move"},  FMove,  0);
        expect_at(c, {pfx, "_rate"},  FRate,  0);
        expect_at(c, {pfx, "_kills"}, FKills, 0);
        expect_at(c, {pfx, "_lives"}, FLives, 3);
        expect_at(c, {pfx, "_over"},  FOver,  0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int             c, s, r, x, k;
        logic [NS-1:0]  v;
        int unsigned    kexp;

        reset      = 1'b1;
        start      = 1'b0;
        hit        = '0;
        touch_edge = '0;
        @(negedge clk);
        @(negedge clk);
        c = cyc + 1;
        expect_reset_vals(c, "rst");
        wait_until(c);
        reset = 1'b0;
        wait_until(c + 2);
        s = cyc;

        // First spawns on the fixed interval.
        expect_at(s + 1,  "move_on",      FMove, 1);
        expect_at(s + 16, "c_en_pre",     FCen,  'h000);
        expect_at(s + 17, "c_en_first",   FCen,  'h001);
        expect_at(s + 33, "c_en_second",  FCen,  'h003);
        // Hit on slot 0.
        expect_at(s + 36, "hit0_c_en",    FCen,   'h002);
        expect_at(s + 36, "hit0_des",     FDes,   'h001);
        expect_at(s + 37, "hit0_des_off", FDes,   'h000);
        expect_at(s + 36, "hit0_kills",   FKills, 1);
        expect_at(s + 36, "hit0_lives",   FLives, 3);
        // Hit and edge together on slot 2: counts as a kill.
        expect_at(s + 49, "slot2_up",     FCen,   'h006);
        expect_at(s + 51, "both2_kills",  FKills, 2);
        expect_at(s + 51, "both2_lives",  FLives, 3);
        expect_at(s + 51, "both2_des",    FDes,   'h004);
        expect_at(s + 51, "both2_c_en",   FCen,   'h002);
        // Double escape on slots 3 and 4.
        expect_at(s + 81, "slot34_up",    FCen,   'h01A);
        expect_at(s + 83, "esc34_lives",  FLives, 1);
        expect_at(s + 83, "esc34_des",    FDes,   'h018);
        expect_at(s + 83, "esc34_c_en",   FCen,   'h002);
        expect_at(s + 83, "esc34_kills",  FKills, 2);
        // start while playing is ignored.
        expect_at(s + 101, "ign_kills",   FKills, 2);
        expect_at(s + 101, "ign_lives",   FLives, 1);
        expect_at(s + 101, "ign_over",    FOver,  0);
        // Full occupancy, dropped attempt, then pointer-ordered refill.
        expect_at(s + 225, "all_fly",     FCen,   'h3FF);
        expect_at(s + 241, "full_drop",   FCen,   'h3FF);
        expect_at(s + 243, "hit35_c_en",  FCen,   'h3D7);
        expect_at(s + 243, "hit35_kills", FKills, 4);
        expect_at(s + 257, "regrant5",    FCen,   'h3F7);
        expect_at(s + 273, "regrant3",    FCen,   'h3FF);
        // Final escape and game over.
        expect_at(s + 275, "last_lives",  FLives, 0);
        expect_at(s + 275, "last_c_en",   FCen,   'h3FE);
        expect_at(s + 275, "last_des",    FDes,   'h001);
        expect_at(s + 275, "last_over0",  FOver,  0);
        expect_at(s + 275, "last_move1",  FMove,  1);
        expect_at(s + 276, "over_flag",   FOver,  1);
        expect_at(s + 276, "over_move",   FMove,  0);
        expect_at(s + 276, "over_des",    FDes,   'h3FE);
        expect_at(s + 276, "over_c_en",   FCen,   'h000);
        expect_at(s + 276, "over_kills",  FKills, 4);
        expect_at(s + 277, "over_des_off", FDes,  'h000);

        pulse_at(s + 0,   1'b1, '0, '0);
        pulse_at(s + 35,  1'b0, 10'h001, '0);
        pulse_at(s + 50,  1'b0, 10'h004, 10'h004);
        pulse_at(s + 82,  1'b0, '0, 10'h018);
        pulse_at(s + 100, 1'b1, '0, '0);
        pulse_at(s + 242, 1'b0, 10'h028, '0);
        pulse_at(s + 274, 1'b0, '0, 10'h001);

        // Restart from game over, then a long run of hits for rate and saturation.
        r = s + 290;
        expect_at(r + 1,  "rs_over",  FOver,  0);
        expect_at(r + 1,  "rs_lives", FLives, 3);
        expect_at(r + 1,  "rs_kills", FKills, 0);
        expect_at(r + 1,  "rs_move",  FMove,  1);
        expect_at(r + 16, "rs_c_en0", FCen,   'h000);
        pulse_at(r, 1'b1, '0, '0);

        for (k = 1; k <= 257; k++) begin
            v    = NS'(1) << ((k - 1) % NS);
            kexp = (k > 255) ? 255 : k;
            expect_at(r + 16 * k + 1, $sformatf("run_c_en_k%0d", k), FCen, 32'(v));
            expect_at(r + 16 * k + 2, $sformatf("run_kills_k%0d", k), FKills, kexp);
            expect_at(r + 16 * k + 2, $sformatf("run_rate_k%0d", k), FRate,
                      (k / 16 > 3) ? 3 : k / 16);
            pulse_at(r + 16 * k + 1, 1'b0, v, '0);
        end

        // Reset mid-game with slot 7 flying.
        x = r + 16 * 258 + 2;
        expect_at(x, "pre_rst_c_en",  FCen,   'h080);
        expect_at(x, "pre_rst_lives", FLives, 3);
        expect_at(x, "pre_rst_move",  FMove,  1);
        expect_reset_vals(x + 1, "mid_rst");
        wait_until(x);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_until(x + 3);

        check_val("sb_left", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
